ysyx_25030085_mem_arbiter: RTL and testbench
============================================

# ysyx_25030085_mem_arbiter

- Shares one memory port between the instruction fetch unit (IFU, word reads) and the load/store unit (LSU, byte/half/word reads and writes).
- Sits between the core's IFU/LSU and the memory/bus bridge.
- Allows one outstanding transaction at a time, with round-robin priority when both requesters are valid.
- Generates byte strobes and lane-shifted write data from the LSU MemOp encoding, rejects misaligned or illegal accesses locally, and returns an error if memory does not respond within a bounded number of cycles.

## Interface
- TIMEOUT, 255: cycles in WAIT with no response before an error response is returned (range 2..255).
- clk  in  1  clock; all registers update on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ifu_req_valid  in  1  IFU request.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- ifu_addr  in  32  fetch byte address.
- ifu_resp_valid  out  1  one-cycle response pulse.
- ifu_rdata  out  32  fetched word.
- ifu_resp_err  out  1  error qualifier, valid with ifu_resp_valid.
- lsu_req_valid / lsu_req_ready  in / out  1  LSU handshake.
- lsu_addr  in  32  byte address.
- lsu_wen  in  1  1 = store.
- lsu_wdata  in  32  store data in low bits.
- lsu_memop  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu; all other codes are illegal.
- lsu_resp_valid / lsu_rdata / lsu_resp_err  out  1/32/1  response; rdata is the raw aligned word (LSU extracts and extends).
- mem_req_valid  out  1  memory request.
- mem_req_ready  in  1  memory accepts.
- mem_addr  out  32  {addr[31:2],2'b00}.
- mem_wen  out  1  write.
- mem_wdata  out  32  lane-replicated data.
- mem_wstrb  out  4  byte enables; 0 for reads.
- mem_resp_valid  in  1  response, earliest the cycle after the request handshake.
- mem_rdata  in  32  read word.
- mem_resp_err  in  1  bus error.

## Operation
- **FSM states:** IDLE, REQ, WAIT, RESP.
- **Arbitration (IDLE only):**
  - Only one valid requester: that requester wins.
  - Both valid: the requester not in last_owner wins. last_owner resets to LSU, so IFU wins first.
  - Only the winner's req_ready is high, and only in IDLE; req_ready is combinational from the valids and the state.
  - Accept = winner valid & ready. On accept, latch owner, addr, wen, wdata, memop, and set last_owner = owner.
- **Alignment and legality check at accept:**
  - IFU: addr[1:0] != 0 is an error.
  - LSU h/hu: addr[0] = 1 is an error.
  - LSU w: addr[1:0] != 0 is an error.
  - LSU illegal memop, or store with memop bu/hu: error.
  - On error: go IDLE -> RESP with err = 1 and rdata = 0. No memory request is issued.
- **Legal accept:** go IDLE -> REQ.
- **REQ:**
  - mem_req_valid = 1 with registered addr, wen, wdata, wstrb, all held stable until mem_req_ready.
  - On mem_req_ready: go to WAIT and clear timeout counter.
- **Write formatting:**
  - sb: wstrb = 4'b0001 << addr[1:0], wdata = {4{d[7:0]}}.
  - sh: wstrb = 4'b0011 << addr[1:0], wdata = {2{d[15:0]}}.
  - sw: wstrb = 4'b1111, wdata = d.
- **WAIT:**
  - On mem_resp_valid: register rdata and err (mem_resp_err), then go to RESP.
  - Otherwise the counter increments.
  - When the counter reaches TIMEOUT-1 with no response: go to RESP with err = 1 and rdata = 0.
- **RESP:** owner's resp_valid = 1 for exactly one cycle, then IDLE. The non-owner's resp_valid stays 0.
- **Stray responses:** mem_resp_valid outside WAIT, including a late response after a timeout, is ignored.

## Timing
- **Reset values:** state IDLE, last_owner LSU, counter 0. All outputs 0 except ready, which follows IDLE arbitration (combinational from the valids).
- **Async reset mid-transaction:** mem_req_valid and resp_valid drop immediately. The transaction is lost with no response.
- **Legal access, zero-wait memory:**
  - Accept at cycle 0.
  - mem_req_valid at cycle 1; handshake there.
  - WAIT at cycle 2; mem_resp_valid there.
  - resp_valid at cycle 3.
  - IDLE at cycle 4; next accept possible at cycle 4.
  - Best-case throughput is one access per 4 cycles.
- **Illegal access:** resp_valid with err at cycle 1, IDLE at cycle 2.
- **Timeout:** resp_valid err appears at WAIT entry + TIMEOUT cycles.
- **Hold rules:** mem_req_valid never deasserts before mem_req_ready. Requester inputs are sampled only at accept.

## Test plan
- **IFU fetch:** IFU fetch 0x8000_0000, mem_req_ready=1, resp next cycle with rdata 0x0000_0093 -> ifu_resp_valid at cycle 3, rdata 0x0000_0093, err 0; lsu_resp_valid stays 0.
- **sb lane formatting:** LSU sb addr 0x8000_0103, wdata 0xAB -> mem_addr 0x8000_0100, wstrb 4'b1000, wdata 0xABABABAB; sh addr 0x8000_0102 wdata 0x1234 -> wstrb 4'b1100, wdata 0x12341234.
- **Round-robin:** both requesters valid in IDLE after reset -> IFU granted first, LSU next; with both held valid for 4 transactions, grants alternate I, L, I, L.
- **Misaligned:** lw at 0x8000_0002 -> no mem_req_valid, lsu_resp_valid with err=1 at cycle 1; memop 3'b011 -> err; IFU addr 0x8000_0001 -> err.
- **Back-pressure and timeout (TIMEOUT=4):**
  - mem_req_ready low 5 cycles -> mem_req_valid and address held stable throughout.
  - No response afterwards -> err resp 4 cycles after WAIT entry.
  - A late mem_resp_valid in IDLE -> no response generated.
- **Async reset:** rst_n low during WAIT -> outputs 0 within the same cycle, state IDLE; the next request completes normally.

Source files
------------

// File: rtl/ysyx_25030085_mem_arbiter_if.sv
// Bundle of IFU, LSU and memory-side signals around the memory arbiter.
// The master modport is the arbiter's view; slave is the surrounding core/bus.
interface ysyx_25030085_mem_arbiter_if;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_resp_valid;
  logic [31:0] ifu_rdata;
  logic        ifu_resp_err;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [2:0]  lsu_memop;
  logic        lsu_resp_valid;
  logic [31:0] lsu_rdata;
  logic        lsu_resp_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic        mem_resp_err;

  modport master (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_memop,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
    input  mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err
  );

  modport slave (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_memop,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
    output mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err
  );
endinterface

// File: rtl/ysyx_25030085_mem_arbiter.sv
// Round-robin IFU/LSU arbiter onto one memory port, one access in flight.
// Formats store lanes, rejects misaligned/illegal ops, times out slow memory.
module ysyx_25030085_mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic clk,
  input logic rst_n,
  ysyx_25030085_mem_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t      st_q, st_d;
  logic        last_q, own_q, wen_q, err_q;
  logic [1:0]  mop_q;
  logic [7:0]  cnt_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        idle, ifu_win, lsu_win, acc, sel;
  logic        bad, lsu_bad, to_hit, resp;
  logic [3:0]  strb;
  logic [31:0] wfmt;

  // owner / last_owner: 1 = LSU, 0 = IFU
  assign idle    = st_q == IDLE;
  assign ifu_win = bus.ifu_req_valid & (~bus.lsu_req_valid | last_q);
  assign lsu_win = bus.lsu_req_valid & (~bus.ifu_req_valid | ~last_q);
  assign bus.ifu_req_ready = idle & ifu_win;
  assign bus.lsu_req_ready = idle & lsu_win;
  assign acc    = bus.ifu_req_ready | bus.lsu_req_ready;
  assign sel    = bus.lsu_req_ready;
  assign to_hit = cnt_q == 8'(TIMEOUT - 1);

  always_comb begin
    lsu_bad = 1'b1;
    unique case (bus.lsu_memop)
      3'b000:  lsu_bad = 1'b0;
      3'b001:  lsu_bad = bus.lsu_addr[0];
      3'b010:  lsu_bad = |bus.lsu_addr[1:0];
      3'b100:  lsu_bad = bus.lsu_wen;
      3'b101:  lsu_bad = bus.lsu_wen | bus.lsu_addr[0];
      default: lsu_bad = 1'b1;
    endcase
  end

  assign bad = sel ? lsu_bad : |bus.ifu_addr[1:0];

  always_comb begin
    strb = 4'b1111;
    wfmt = wdata_q;
    unique case (mop_q)
      2'b00: begin
        strb = 4'b0001 << addr_q[1:0];
        wfmt = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        strb = 4'b0011 << addr_q[1:0];
        wfmt = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE: if (acc) st_d = bad ? RESP : REQ;
      REQ:  if (bus.mem_req_ready) st_d = WAIT;
      WAIT: if (bus.mem_resp_valid || to_hit) st_d = RESP;
      RESP: st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      last_q  <= 1'b1;
      own_q   <= 1'b0;
      wen_q   <= 1'b0;
      err_q   <= 1'b0;
      mop_q   <= 2'b10;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      st_q <= st_d;
      unique case (st_q)
        IDLE: if (acc) begin
          own_q   <= sel;
          last_q  <= sel;
          addr_q  <= sel ? bus.lsu_addr : bus.ifu_addr;
          wen_q   <= sel & bus.lsu_wen;
          wdata_q <= sel ? bus.lsu_wdata : 32'h0;
          mop_q   <= sel ? bus.lsu_memop[1:0] : 2'b10;
          err_q   <= bad;
          rdata_q <= '0;
        end
        REQ: if (bus.mem_req_ready) cnt_q <= '0;
        WAIT: begin
          if (bus.mem_resp_valid) begin
            rdata_q <= bus.mem_rdata;
            err_q   <= bus.mem_resp_err;
          end else if (to_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_req_valid = st_q == REQ;
  assign bus.mem_addr  = {addr_q[31:2], 2'b00};
  assign bus.mem_wen   = wen_q;
  assign bus.mem_wdata = wfmt;
  assign bus.mem_wstrb = wen_q ? strb : 4'b0000;

  assign resp = st_q == RESP;
  assign bus.ifu_resp_valid = resp & ~own_q;
  assign bus.lsu_resp_valid = resp & own_q;
  assign bus.ifu_rdata    = bus.ifu_resp_valid ? rdata_q : 32'h0;
  assign bus.lsu_rdata    = bus.lsu_resp_valid ? rdata_q : 32'h0;
  assign bus.ifu_resp_err = bus.ifu_resp_valid & err_q;
  assign bus.lsu_resp_err = bus.lsu_resp_valid & err_q;
endmodule

// File: tb/tb_ysyx_25030085_mem_arbiter.sv
// Scoreboard bench for the memory arbiter: responses are queued at issue
// and checked by a monitor; each task also checks its own cycle timing.
module tb_ysyx_25030085_mem_arbiter;
  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ysyx_25030085_mem_arbiter_if bus();

  ysyx_25030085_mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    bit          lsu;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad = 0;

  bit ready_en = 1'b1;
  bit resp_en = 1'b1;
  bit err_en = 1'b0;
  bit stray_en = 1'b0;
  bit hs_pend = 1'b0;
  bit hold_pend = 1'b0;
  logic [31:0] hs_addr = '0;
  logic [31:0] hold_addr = '0;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h8000_0000) ? 32'h0000_0093 : (a ^ 32'hC0DE_0000);
  endfunction

  // memory model: responds the cycle after a handshake when enabled
  always @(negedge clk) begin
    #2;
    bus.mem_resp_valid = (hs_pend && resp_en) || stray_en;
    bus.mem_rdata = hs_pend ? mem_fn(hs_addr) : 32'h0;
    bus.mem_resp_err = hs_pend && err_en;
    if (hold_pend && rst_n) begin
      total++;
      if (bus.mem_req_valid !== 1'b1 || bus.mem_addr !== hold_addr) begin
        bad++;
        $display("FAIL req_hold valid=%b addr=%h required valid=1 addr=%h",
                 bus.mem_req_valid, bus.mem_addr, hold_addr);
      end
    end
    if (bus.mem_req_valid === 1'b1 && bus.mem_wen === 1'b0) begin
      total++;
      if (bus.mem_wstrb !== 4'b0000) begin
        bad++;
        $display("FAIL read_wstrb got=%b required=0000", bus.mem_wstrb);
      end
    end
    bus.mem_req_ready = ready_en;
    hs_pend = (bus.mem_req_valid === 1'b1) && ready_en;
    hs_addr = bus.mem_addr;
    hold_pend = (bus.mem_req_valid === 1'b1) && !ready_en;
    hold_addr = bus.mem_addr;
  end

  exp_t e;
  logic gl, ge;
  logic [31:0] gd;

  always @(negedge clk) begin
    if (bus.ifu_resp_valid === 1'b1 || bus.lsu_resp_valid === 1'b1) begin
      total++;
      gl = bus.lsu_resp_valid;
      gd = gl ? bus.lsu_rdata : bus.ifu_rdata;
      ge = gl ? bus.lsu_resp_err : bus.ifu_resp_err;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_resp lsu=%b rdata=%h err=%b required none",
                 gl, gd, ge);
      end else begin
        e = sbq.pop_front();
        if ((bus.ifu_resp_valid && bus.lsu_resp_valid) || gl !== e.lsu ||
            gd !== e.rdata || ge !== e.err) begin
          bad++;
          $display("FAIL resp got lsu=%b rdata=%h err=%b required lsu=%b rdata=%h err=%b",
                   gl, gd, ge, e.lsu, e.rdata, e.err);
        end
      end
    end
  end

  task automatic idle_in();
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b0;
  endtask

  task automatic drv_ifu(input logic [31:0] a);
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr = a;
  endtask

  task automatic drv_lsu(input logic [31:0] a, input logic w,
                         input logic [31:0] d, input logic [2:0] m);
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr = a;
    bus.lsu_wen = w;
    bus.lsu_wdata = d;
    bus.lsu_memop = m;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sbq.size() != 0 && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL %s_drain pending=%0d required=0", name, sbq.size());
      sbq.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    total++;
    if (bus.mem_req_valid !== 1'b0) begin
      bad++; $display("FAIL rst_mem_req_valid got=%b required=0", bus.mem_req_valid);
    end
    total++;
    if (bus.ifu_resp_valid !== 1'b0 || bus.lsu_resp_valid !== 1'b0) begin
      bad++; $display("FAIL rst_resp_valid got=%b%b required=00",
                      bus.ifu_resp_valid, bus.lsu_resp_valid);
    end
    total++;
    if (bus.mem_wstrb !== 4'b0 || bus.mem_wen !== 1'b0) begin
      bad++; $display("FAIL rst_mem_wr got=%b/%b required=0000/0", bus.mem_wstrb, bus.mem_wen);
    end
    total++;
    if (bus.ifu_req_ready !== 1'b0 || bus.lsu_req_ready !== 1'b0) begin
      bad++; $display("FAIL rst_ready_idle got=%b%b required=00",
                      bus.ifu_req_ready, bus.lsu_req_ready);
    end
    bus.lsu_req_valid = 1'b1;
    #1;
    total++;
    if (bus.lsu_req_ready !== 1'b1 || bus.ifu_req_ready !== 1'b0) begin
      bad++; $display("FAIL rst_ready_follow got=%b%b required=01",
                      bus.ifu_req_ready, bus.lsu_req_ready);
    end
    idle_in();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_ifu_fetch();
    drv_ifu(32'h8000_0000);
    sbq.push_back('{1'b0, 32'h0000_0093, 1'b0});
    #1;
    total++;
    if (bus.ifu_req_ready !== 1'b1) begin
      bad++; $display("FAIL fetch_ready got=%b required=1", bus.ifu_req_ready);
    end
    @(negedge clk);
    idle_in();
    #1;
    total++;
    if (bus.mem_req_valid !== 1'b1 || bus.mem_addr !== 32'h8000_0000) begin
      bad++; $display("FAIL fetch_req got=%b/%h required=1/80000000",
                      bus.mem_req_valid, bus.mem_addr);
    end
    @(negedge clk);
    #1;
    total++;
    if (bus.ifu_resp_valid !== 1'b0) begin
      bad++; $display("FAIL fetch_early got=%b required=0", bus.ifu_resp_valid);
    end
    @(negedge clk);
    #1;
    total++;
    if (bus.ifu_resp_valid !== 1'b1 || bus.lsu_resp_valid !== 1'b0) begin
      bad++; $display("FAIL fetch_c3 got=%b%b required=10",
                      bus.ifu_resp_valid, bus.lsu_resp_valid);
    end
    @(negedge clk);
    #1;
    total++;
    if (bus.ifu_resp_valid !== 1'b0) begin
      bad++; $display("FAIL fetch_pulse got=%b required=0", bus.ifu_resp_valid);
    end
    wait_drain("fetch");
  endtask

  task automatic test_lane();
    logic [31:0] ta [5];
    logic [31:0] td [5];
    logic [2:0]  tm [5];
    logic        tw [5];
    logic [3:0]  xs [5];
    logic [31:0] xd [5];
    ta = '{32'h8000_0103, 32'h8000_0102, 32'h8000_0104, 32'h8000_0101, 32'h8000_0101};
    td = '{32'hFFFF_FFAB, 32'h0000_1234, 32'hDEAD_BEEF, 32'h0000_005A, 32'h1111_1111};
    tm = '{3'b000, 3'b001, 3'b010, 3'b000, 3'b100};
    tw = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    xs = '{4'b1000, 4'b1100, 4'b1111, 4'b0010, 4'b0000};
    xd = '{32'hABAB_ABAB, 32'h1234_1234, 32'hDEAD_BEEF, 32'h5A5A_5A5A, 32'h0};
    for (int i = 0; i < 5; i++) begin
      drv_lsu(ta[i], tw[i], td[i], tm[i]);
      sbq.push_back('{1'b1, mem_fn({ta[i][31:2], 2'b00}), 1'b0});
      @(negedge clk);
      idle_in();
      #1;
      total++;
      if (bus.mem_req_valid !== 1'b1 || bus.mem_addr !== {ta[i][31:2], 2'b00} ||
          bus.mem_wstrb !== xs[i] || bus.mem_wen !== tw[i] ||
          (tw[i] && bus.mem_wdata !== xd[i])) begin
        bad++;
        $display("FAIL lane%0d got v=%b a=%h s=%b w=%b d=%h required v=1 a=%h s=%b w=%b d=%h",
                 i, bus.mem_req_valid, bus.mem_addr, bus.mem_wstrb, bus.mem_wen,
                 bus.mem_wdata, {ta[i][31:2], 2'b00}, xs[i], tw[i], xd[i]);
      end
      repeat (3) @(negedge clk);
    end
    wait_drain("lane");
  endtask

  task automatic test_round_robin();
    bit el;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drv_ifu(32'h8000_0010);
    drv_lsu(32'h8000_0020, 1'b0, 32'h0, 3'b010);
    for (int k = 0; k < 4; k++) begin
      el = k[0];
      #1;
      total++;
      if (bus.ifu_req_ready !== !el || bus.lsu_req_ready !== el) begin
        bad++; $display("FAIL rr_grant%0d got=%b%b required=%b%b", k,
                        bus.ifu_req_ready, bus.lsu_req_ready, !el, el);
      end
      sbq.push_back('{el, mem_fn(el ? 32'h8000_0020 : 32'h8000_0010), 1'b0});
      @(negedge clk);
      @(negedge clk);
      #1;
      total++;
      if (bus.ifu_req_ready !== 1'b0 || bus.lsu_req_ready !== 1'b0) begin
        bad++; $display("FAIL rr_busy%0d got=%b%b required=00", k,
                        bus.ifu_req_ready, bus.lsu_req_ready);
      end
      @(negedge clk);
      @(negedge clk);
    end
    idle_in();
    wait_drain("rr");
  endtask

  task automatic test_misaligned();
    bit          tl [5];
    logic [31:0] ta [5];
    logic        tw [5];
    logic [2:0]  tm [5];
    logic        rv;
    tl = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    ta = '{32'h8000_0002, 32'h8000_0000, 32'h8000_0001, 32'h8000_0000, 32'h8000_0001};
    tw = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tm = '{3'b010, 3'b011, 3'b010, 3'b100, 3'b001};
    for (int i = 0; i < 5; i++) begin
      if (tl[i]) drv_lsu(ta[i], tw[i], 32'h55, tm[i]);
      else drv_ifu(ta[i]);
      sbq.push_back('{tl[i], 32'h0, 1'b1});
      @(negedge clk);
      idle_in();
      #1;
      rv = tl[i] ? bus.lsu_resp_valid : bus.ifu_resp_valid;
      total++;
      if (bus.mem_req_valid !== 1'b0 || rv !== 1'b1) begin
        bad++; $display("FAIL misal%0d_c1 got req=%b resp=%b required req=0 resp=1",
                        i, bus.mem_req_valid, rv);
      end
      @(negedge clk);
      #1;
      rv = tl[i] ? bus.lsu_resp_valid : bus.ifu_resp_valid;
      total++;
      if (bus.mem_req_valid !== 1'b0 || rv !== 1'b0) begin
        bad++; $display("FAIL misal%0d_c2 got req=%b resp=%b required req=0 resp=0",
                        i, bus.mem_req_valid, rv);
      end
    end
    wait_drain("misal");
  endtask

  task automatic test_bus_err();
    err_en = 1'b1;
    drv_lsu(32'h8000_0030, 1'b0, 32'h0, 3'b010);
    sbq.push_back('{1'b1, mem_fn(32'h8000_0030), 1'b1});
    @(negedge clk);
    idle_in();
    wait_drain("buserr");
    err_en = 1'b0;
  endtask

  task automatic test_timeout();
    ready_en = 1'b0;
    resp_en = 1'b0;
    drv_ifu(32'h8000_0040);
    sbq.push_back('{1'b0, 32'h0, 1'b1});
    @(negedge clk);
    idle_in();
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) @(negedge clk);
      #1;
      total++;
      if (bus.mem_req_valid !== 1'b1 || bus.mem_addr !== 32'h8000_0040) begin
        bad++; $display("FAIL bp_c%0d got=%b/%h required=1/80000040",
                        c, bus.mem_req_valid, bus.mem_addr);
      end
    end
    @(negedge clk);
    ready_en = 1'b1;
    @(negedge clk);
    ready_en = 1'b0;
    for (int c = 7; c <= 10; c++) begin
      #1;
      total++;
      if (bus.ifu_resp_valid !== 1'b0) begin
        bad++; $display("FAIL to_early_c%0d got=%b required=0", c, bus.ifu_resp_valid);
      end
      @(negedge clk);
    end
    #1;
    total++;
    if (bus.ifu_resp_valid !== 1'b1 || bus.ifu_resp_err !== 1'b1) begin
      bad++; $display("FAIL to_resp got=%b err=%b required=1 err=1",
                      bus.ifu_resp_valid, bus.ifu_resp_err);
    end
    @(negedge clk);
    stray_en = 1'b1;
    @(negedge clk);
    stray_en = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      total++;
      if (bus.ifu_resp_valid !== 1'b0 || bus.lsu_resp_valid !== 1'b0 ||
          bus.mem_req_valid !== 1'b0) begin
        bad++; $display("FAIL stray%0d got=%b%b%b required=000", c,
                        bus.ifu_resp_valid, bus.lsu_resp_valid, bus.mem_req_valid);
      end
      @(negedge clk);
    end
    ready_en = 1'b1;
    resp_en = 1'b1;
    wait_drain("timeout");
  endtask

  task automatic test_async_reset();
    resp_en = 1'b0;
    drv_ifu(32'h8000_0080);
    @(negedge clk);
    idle_in();
    #1;
    total++;
    if (bus.mem_req_valid !== 1'b1) begin
      bad++; $display("FAIL ar_req got=%b required=1", bus.mem_req_valid);
    end
    @(negedge clk);
    @(negedge clk);
    drv_ifu(32'h8000_0084);
    #1;
    total++;
    if (bus.ifu_req_ready !== 1'b0) begin
      bad++; $display("FAIL ar_busy got=%b required=0", bus.ifu_req_ready);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.ifu_req_ready !== 1'b1 || bus.mem_req_valid !== 1'b0 ||
        bus.ifu_resp_valid !== 1'b0 || bus.lsu_resp_valid !== 1'b0) begin
      bad++; $display("FAIL ar_drop got rdy=%b req=%b resp=%b%b required 1/0/00",
                      bus.ifu_req_ready, bus.mem_req_valid,
                      bus.ifu_resp_valid, bus.lsu_resp_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    resp_en = 1'b1;
    sbq.push_back('{1'b0, mem_fn(32'h8000_0084), 1'b0});
    @(negedge clk);
    idle_in();
    wait_drain("areset");
  endtask

  initial begin
    bus.ifu_req_valid = 1'b0;
    bus.ifu_addr = '0;
    bus.lsu_req_valid = 1'b0;
    bus.lsu_addr = '0;
    bus.lsu_wen = 1'b0;
    bus.lsu_wdata = '0;
    bus.lsu_memop = 3'b010;
    test_reset();
    test_ifu_fetch();
    test_lane();
    test_round_robin();
    test_misaligned();
    test_bus_err();
    test_timeout();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
